// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - ALU op type and memory-port interface for multicycle_ctrl
//
// multicycle_ctrl_pkg : alu_ctrl_t, the operation code driven to the shared ALU.
// multicycle_ctrl_if  : ready/valid memory request port.
//   mem_valid  request active (held until mem_ready)
//   mem_we     request is a write
//   addr_sel   0: address is PC, 1: address is ALUOut
//   mem_ready  memory accepted the request / returned data
//   master modport = controller side, slave modport = memory side.

package multicycle_ctrl_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_SRC2 = 4'd10
  } alu_ctrl_t;
endpackage

interface multicycle_ctrl_if;
  logic mem_valid;
  logic mem_we;
  logic addr_sel;
  logic mem_ready;

  modport master (output mem_valid, output mem_we, output addr_sel, input mem_ready);
  modport slave  (input mem_valid, input mem_we, input addr_sel, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I control FSM
//
// Ports:
//   clk, reset              core clock, synchronous active-high reset
//   mem                     memory port (multicycle_ctrl_if.master)
//   opcode/funct3/funct7b5  instruction fields from IR
//   zero/lt/ltu             datapath flags for branch resolution
//   pc_write/ir_write/reg_write  register enables
//   result_sel, ALU_src1_sel, ALU_src2_sel, ALU_ctrl, imm_sel  datapath selects
//   illegal                 sticky trap flag

module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  multicycle_ctrl_if.master        mem,
  input  logic [6:0]               opcode,
  input  logic [2:0]               funct3,
  input  logic                     funct7b5,
  input  logic                     zero,
  input  logic                     lt,
  input  logic                     ltu,
  output logic                     pc_write,
  output logic                     ir_write,
  output logic                     reg_write,
  output logic [1:0]               result_sel,
  output logic [1:0]               ALU_src1_sel,
  output logic [1:0]               ALU_src2_sel,
  output alu_ctrl_t                ALU_ctrl,
  output logic [2:0]               imm_sel,
  output logic                     illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECR, S_EXECI,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALLINK, S_LUI, S_AUIPC, S_TRAP
  } state_t;

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;

  logic      mem_valid_o, mem_we_o, addr_sel_o;
  alu_ctrl_t alu_op;
  logic [2:0] imm_dec;
  logic      taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // funct3/funct7b5 -> ALU op; SUB only exists for R-type
  always_comb begin
    alu_op = ALU_ADD;
    case (funct3)
      3'b000: alu_op = (opcode == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001: alu_op = ALU_SLL;
      3'b010: alu_op = ALU_SLT;
      3'b011: alu_op = ALU_SLTU;
      3'b100: alu_op = ALU_XOR;
      3'b101: alu_op = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110: alu_op = ALU_OR;
      3'b111: alu_op = ALU_AND;
    endcase
  end

  always_comb begin
    imm_dec = 3'd0;
    case (opcode)
      OP_STORE:        imm_dec = 3'd1;
      OP_BRANCH:       imm_dec = 3'd2;
      OP_LUI, OP_AUIPC: imm_dec = 3'd3;
      OP_JAL:          imm_dec = 3'd4;
      default:         imm_dec = 3'd0;
    endcase
  end

  // funct3[2:1]==01 is not a branch encoding and never redirects
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000: taken = zero;
      3'b001: taken = ~zero;
      3'b100: taken = lt;
      3'b101: taken = ~lt;
      3'b110: taken = ltu;
      3'b111: taken = ~ltu;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    mem_valid_o  = 1'b0;
    mem_we_o     = 1'b0;
    addr_sel_o   = 1'b0;
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    result_sel   = 2'd0;
    ALU_src1_sel = 2'd0;
    ALU_src2_sel = 2'd0;
    ALU_ctrl     = ALU_ADD;
    imm_sel      = 3'd0;

    case (state_q)
      S_FETCH: begin
        mem_valid_o  = 1'b1;
        ALU_src2_sel = 2'd2;
        result_sel   = 2'd2;
        if (mem.mem_ready) begin
          pc_write = 1'b1;
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        ALU_src1_sel = 2'd1;
        ALU_src2_sel = 2'd1;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:      state_d = S_EXECR;
          OP_I:      state_d = S_EXECI;
          OP_BRANCH: state_d = S_BRANCH;
          OP_JAL:    state_d = S_JAL;
          OP_JALR:   state_d = S_JALR;
          OP_LUI:    state_d = S_LUI;
          OP_AUIPC:  state_d = S_AUIPC;
          default:   state_d = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALU_src1_sel = 2'd2;
        ALU_src2_sel = 2'd1;
        state_d      = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_valid_o = 1'b1;
        addr_sel_o  = 1'b1;
        if (mem.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_sel = 2'd1;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_valid_o = 1'b1;
        mem_we_o    = 1'b1;
        addr_sel_o  = 1'b1;
        if (mem.mem_ready) state_d = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        ALU_src1_sel = 2'd2;
        ALU_src2_sel = (state_q == S_EXECI) ? 2'd1 : 2'd0;
        ALU_ctrl     = alu_op;
        state_d      = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        ALU_src1_sel = 2'd2;
        ALU_ctrl     = ALU_SUB;
        pc_write     = taken;
        state_d      = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target computed in DECODE while the ALU builds the link
        pc_write     = 1'b1;
        ALU_src1_sel = 2'd1;
        ALU_src2_sel = 2'd2;
        state_d      = S_ALUWB;
      end
      S_JALR: begin
        ALU_src1_sel = 2'd2;
        ALU_src2_sel = 2'd1;
        result_sel   = 2'd2;
        pc_write     = 1'b1;
        state_d      = S_JALLINK;
      end
      S_JALLINK: begin
        ALU_src1_sel = 2'd1;
        ALU_src2_sel = 2'd2;
        state_d      = S_ALUWB;
      end
      S_LUI: begin
        ALU_src2_sel = 2'd1;
        ALU_ctrl     = ALU_SRC2;
        state_d      = S_ALUWB;
      end
      S_AUIPC: begin
        ALU_src1_sel = 2'd1;
        ALU_src2_sel = 2'd1;
        state_d      = S_ALUWB;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    // immediate format only matters when the ALU actually consumes imm_ext
    if (ALU_src2_sel == 2'd1) imm_sel = imm_dec;

    // reset forces an idle bus immediately, including mid-handshake
    if (reset) begin
      mem_valid_o  = 1'b0;
      mem_we_o     = 1'b0;
      addr_sel_o   = 1'b0;
      pc_write     = 1'b0;
      ir_write     = 1'b0;
      reg_write    = 1'b0;
      result_sel   = 2'd0;
      ALU_src1_sel = 2'd0;
      ALU_src2_sel = 2'd0;
      ALU_ctrl     = ALU_ADD;
      imm_sel      = 3'd0;
    end

    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  assign mem.mem_valid = mem_valid_o;
  assign mem.mem_we    = mem_we_o;
  assign mem.addr_sel  = addr_sel_o;
  assign illegal       = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic       mv, we, as, pcw, irw, rw;
    logic [1:0] rs, s1, s2;
    logic [3:0] alu;
    logic [2:0] imm;
    logic       ill;
  } out_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7, z, l, lu;
    int         key_alu;
    int         key_pcw;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic funct7b5 = 1'b0, zero = 1'b0, lt = 1'b0, ltu = 1'b0;
  logic pc_write, ir_write, reg_write, illegal;
  logic [1:0] result_sel, ALU_src1_sel, ALU_src2_sel;
  alu_ctrl_t ALU_ctrl;
  logic [2:0] imm_sel;

  int checks = 0;
  int failures = 0;
  logic [2:0] cur_imm = 3'd0;

  multicycle_ctrl_if mif();

  multicycle_ctrl #(.TRAP_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .reset(reset), .mem(mif),
    .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .lt(lt), .ltu(ltu),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
    .result_sel(result_sel), .ALU_src1_sel(ALU_src1_sel), .ALU_src2_sel(ALU_src2_sel),
    .ALU_ctrl(ALU_ctrl), .imm_sel(imm_sel), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      OP_STORE:         return 3'd1;
      OP_BRANCH:        return 3'd2;
      OP_LUI, OP_AUIPC: return 3'd3;
      OP_JAL:           return 3'd4;
      default:          return 3'd0;
    endcase
  endfunction

  function automatic out_t o(input logic [1:0] s1, input logic [1:0] s2, input logic [3:0] alu,
                             input logic [1:0] rs, input logic pcw, input logic rw);
    out_t e;
    e = '0;
    e.s1 = s1; e.s2 = s2; e.alu = alu; e.rs = rs; e.pcw = pcw; e.rw = rw;
    e.imm = (s2 == 2'd1) ? cur_imm : 3'd0;
    return e;
  endfunction

  // compare at the falling edge, then advance to just after the next rising edge
  task automatic cyc(input out_t e, input string nm, input int ka = -1, input int kp = -1);
    out_t act;
    @(negedge clk);
    act = '{mv: mif.mem_valid, we: mif.mem_we, as: mif.addr_sel, pcw: pc_write,
            irw: ir_write, rw: reg_write, rs: result_sel, s1: ALU_src1_sel,
            s2: ALU_src2_sel, alu: ALU_ctrl, imm: imm_sel, ill: illegal};
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, e);
    end
    if (ka >= 0) begin
      checks++;
      if (ALU_ctrl !== ka[3:0]) begin
        failures++;
        $display("FAIL %s.alu: got %0d expected %0d", nm, ALU_ctrl, ka);
      end
    end
    if (kp >= 0) begin
      checks++;
      if (pc_write !== kp[0]) begin
        failures++;
        $display("FAIL %s.pcw: got %0b expected %0b", nm, pc_write, kp[0]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic mem_phase(input out_t e, input int waits, input bit is_fetch, input string nm);
    out_t d;
    for (int w = 0; w < waits; w++) begin
      mif.mem_ready = 1'b0;
      cyc(e, nm);
    end
    mif.mem_ready = 1'b1;
    d = e;
    if (is_fetch) begin d.pcw = 1'b1; d.irw = 1'b1; end
    cyc(d, nm);
  endtask

  task automatic do_reset(input int n, input logic ill_before);
    out_t z;
    z = '0;
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      z.ill = (i == 0) ? ill_before : 1'b0;
      cyc(z, "reset");
    end
    reset = 1'b0;
  endtask

  // reference: the state sequence each instruction class walks through
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic z, input logic l, input logic lu,
                           input int wf, input int wm, input int ka, input int kp,
                           input string tag);
    out_t e;
    logic tk;
    alu_ctrl_t alu_tab [8];
    logic [3:0] a;
    alu_tab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    opcode = op; funct3 = f3; funct7b5 = f7; zero = z; lt = l; ltu = lu;
    cur_imm = imm_of(op);
    e = o(2'd0, 2'd2, ALU_ADD, 2'd2, 1'b0, 1'b0);
    e.mv = 1'b1;
    mem_phase(e, wf, 1'b1, {tag, ".fetch"});
    cyc(o(2'd1, 2'd1, ALU_ADD, 2'd0, 1'b0, 1'b0), {tag, ".decode"});
    case (op)
      OP_LOAD, OP_STORE: begin
        cyc(o(2'd2, 2'd1, ALU_ADD, 2'd0, 1'b0, 1'b0), {tag, ".memadr"});
        e = o(2'd0, 2'd0, ALU_ADD, 2'd0, 1'b0, 1'b0);
        e.mv = 1'b1; e.as = 1'b1; e.we = (op == OP_STORE);
        mem_phase(e, wm, 1'b0, {tag, ".mem"});
        if (op == OP_LOAD) cyc(o(2'd0, 2'd0, ALU_ADD, 2'd1, 1'b0, 1'b1), {tag, ".memwb"});
      end
      OP_R, OP_I: begin
        a = alu_tab[f3];
        if (f3 == 3'd0 && op == OP_R && f7) a = ALU_SUB;
        if (f3 == 3'd5 && f7) a = ALU_SRA;
        cyc(o(2'd2, (op == OP_I) ? 2'd1 : 2'd0, a, 2'd0, 1'b0, 1'b0), {tag, ".exec"}, ka, kp);
        cyc(o(2'd0, 2'd0, ALU_ADD, 2'd0, 1'b0, 1'b1), {tag, ".aluwb"});
      end
      OP_BRANCH: begin
        tk = (f3[2:1] == 2'b01) ? 1'b0 : ((f3[2] ? (f3[1] ? lu : l) : z) ^ f3[0]);
        cyc(o(2'd2, 2'd0, ALU_SUB, 2'd0, tk, 1'b0), {tag, ".branch"}, ka, kp);
      end
      OP_JAL: begin
        cyc(o(2'd1, 2'd2, ALU_ADD, 2'd0, 1'b1, 1'b0), {tag, ".jal"});
        cyc(o(2'd0, 2'd0, ALU_ADD, 2'd0, 1'b0, 1'b1), {tag, ".aluwb"});
      end
      OP_JALR: begin
        cyc(o(2'd2, 2'd1, ALU_ADD, 2'd2, 1'b1, 1'b0), {tag, ".jalr"});
        cyc(o(2'd1, 2'd2, ALU_ADD, 2'd0, 1'b0, 1'b0), {tag, ".jallink"});
        cyc(o(2'd0, 2'd0, ALU_ADD, 2'd0, 1'b0, 1'b1), {tag, ".aluwb"});
      end
      OP_LUI: begin
        cyc(o(2'd0, 2'd1, ALU_SRC2, 2'd0, 1'b0, 1'b0), {tag, ".lui"});
        cyc(o(2'd0, 2'd0, ALU_ADD, 2'd0, 1'b0, 1'b1), {tag, ".aluwb"});
      end
      default: begin
        cyc(o(2'd1, 2'd1, ALU_ADD, 2'd0, 1'b0, 1'b0), {tag, ".auipc"});
        cyc(o(2'd0, 2'd0, ALU_ADD, 2'd0, 1'b0, 1'b1), {tag, ".aluwb"});
      end
    endcase
  endtask

  initial begin
    vec_t vecs [13];
    logic [6:0] ops [9];
    out_t e;

    vecs[0]  = '{OP_I,      3'd0, 1'b0, 1'b0, 1'b0, 1'b0, int'(ALU_ADD),  -1};
    vecs[1]  = '{OP_R,      3'd0, 1'b1, 1'b0, 1'b0, 1'b0, int'(ALU_SUB),  -1};
    vecs[2]  = '{OP_I,      3'd0, 1'b1, 1'b0, 1'b0, 1'b0, int'(ALU_ADD),  -1};
    vecs[3]  = '{OP_R,      3'd5, 1'b1, 1'b0, 1'b0, 1'b0, int'(ALU_SRA),  -1};
    vecs[4]  = '{OP_I,      3'd5, 1'b1, 1'b0, 1'b0, 1'b0, int'(ALU_SRA),  -1};
    vecs[5]  = '{OP_R,      3'd5, 1'b0, 1'b0, 1'b0, 1'b0, int'(ALU_SRL),  -1};
    vecs[6]  = '{OP_R,      3'd3, 1'b0, 1'b0, 1'b0, 1'b0, int'(ALU_SLTU), -1};
    vecs[7]  = '{OP_I,      3'd7, 1'b0, 1'b0, 1'b0, 1'b0, int'(ALU_AND),  -1};
    vecs[8]  = '{OP_BRANCH, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, int'(ALU_SUB),  1};
    vecs[9]  = '{OP_BRANCH, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, int'(ALU_SUB),  0};
    vecs[10] = '{OP_BRANCH, 3'd6, 1'b0, 1'b0, 1'b0, 1'b1, int'(ALU_SUB),  1};
    vecs[11] = '{OP_BRANCH, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, int'(ALU_SUB),  0};
    vecs[12] = '{OP_BRANCH, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1, int'(ALU_SUB),  0};
    ops = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

    mif.mem_ready = 1'b1;
    #1;
    do_reset(3, 1'b0);

    foreach (vecs[i])
      run_instr(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z, vecs[i].l, vecs[i].lu,
                0, 0, vecs[i].key_alu, vecs[i].key_pcw, $sformatf("vec%0d", i));

    // load with four stalled cycles in MEMRD and a stalled fetch
    run_instr(OP_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2, 4, -1, -1, "lw_stall");

    // reset while a store is waiting for mem_ready
    opcode = OP_STORE; funct3 = 3'd2; cur_imm = imm_of(OP_STORE);
    e = o(2'd0, 2'd2, ALU_ADD, 2'd2, 1'b0, 1'b0); e.mv = 1'b1;
    mem_phase(e, 0, 1'b1, "swrst.fetch");
    cyc(o(2'd1, 2'd1, ALU_ADD, 2'd0, 1'b0, 1'b0), "swrst.decode");
    cyc(o(2'd2, 2'd1, ALU_ADD, 2'd0, 1'b0, 1'b0), "swrst.memadr");
    e = '0; e.mv = 1'b1; e.we = 1'b1; e.as = 1'b1;
    mif.mem_ready = 1'b0;
    cyc(e, "swrst.wait");
    cyc(e, "swrst.wait");
    do_reset(1, 1'b0);
    e = o(2'd0, 2'd2, ALU_ADD, 2'd2, 1'b0, 1'b0); e.mv = 1'b1;
    cyc(e, "swrst.refetch");
    mif.mem_ready = 1'b1;
    e.pcw = 1'b1; e.irw = 1'b1;
    opcode = OP_LUI; cur_imm = imm_of(OP_LUI);
    cyc(e, "swrst.refetch_go");
    cyc(o(2'd1, 2'd1, ALU_ADD, 2'd0, 1'b0, 1'b0), "swrst.decode2");
    cyc(o(2'd0, 2'd1, ALU_SRC2, 2'd0, 1'b0, 1'b0), "swrst.lui");
    cyc(o(2'd0, 2'd0, ALU_ADD, 2'd0, 1'b0, 1'b1), "swrst.aluwb");

    for (int n = 0; n < 60; n++) begin
      logic [6:0] op;
      op = ops[$urandom_range(0, 8)];
      run_instr(op, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), -1, -1, $sformatf("rnd%0d", n));
    end

    // illegal opcode locks in TRAP until reset
    opcode = 7'h7F; cur_imm = imm_of(7'h7F);
    e = o(2'd0, 2'd2, ALU_ADD, 2'd2, 1'b1, 1'b0); e.mv = 1'b1; e.irw = 1'b1;
    cyc(e, "trap.fetch");
    cyc(o(2'd1, 2'd1, ALU_ADD, 2'd0, 1'b0, 1'b0), "trap.decode");
    e = '0; e.ill = 1'b1;
    for (int i = 0; i < 10; i++) cyc(e, "trap.hold");
    do_reset(1, 1'b1);
    run_instr(OP_I, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, int'(ALU_ADD), -1, "post_trap");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
